// File: rtl/shift_pkg.sv
// Shared definitions for the serial link blocks (serializer, framer, parity).
package shift_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } shift_state_e;

    // Bits needed to index 0..max-1; never less than one bit.
    function automatic int unsigned cnt_width(input int unsigned max);
        return (max > 1) ? $clog2(max) : 1;
    endfunction

endpackage

// File: rtl/bit_counter.sv
// Mod-Max counter with synchronous clear, count enable and terminal-count flag.
module bit_counter
    import shift_pkg::*;
#(
    parameter int unsigned Max = 8
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        clr,
    input  logic                        en,
    output logic [cnt_width(Max)-1:0]   count,
    output logic                        tc_c
);

    localparam int unsigned CntW = cnt_width(Max);
    localparam logic [CntW-1:0] LastVal = CntW'(Max - 1);

    assign tc_c = (count == LastVal);

    // Clear takes priority; wraps to zero after the terminal value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc_c ? '0 : count + CntW'(1);
        end
    end

endmodule

// File: rtl/shift_out_serializer.sv
// Parallel-to-serial transmitter: accepts a word over valid/ready and sends it LSB-first,
// one bit per shift_en tick, with zero-gap reload on the last bit.
module shift_out_serializer
    import shift_pkg::*;
#(
    parameter int unsigned Width     = 8,
    parameter logic        IdleValue = 1'b0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [Width-1:0] load_data,
    input  logic             shift_en,
    output logic             serial_out,
    output logic             busy,
    output logic             done
);

    localparam int unsigned CntW = cnt_width(Width);
    localparam logic [CntW-1:0] LastIdx = CntW'(Width - 1);

    if (Width < 2) begin : g_width_check
        $error("shift_out_serializer: Width must be >= 2");
    end

    shift_state_e     state;
    logic [Width-1:0] sreg;
    logic [CntW-1:0]  cnt;
    logic             tc_c;
    logic             tick_c;
    logic             last_c;
    logic             accept_c;

    // Ready depends only on state, shift_en and the counter, never on load_valid.
    assign tick_c     = (state == SHIFT) && shift_en;
    assign last_c     = tick_c && tc_c;
    assign load_ready = (state == IDLE) || last_c;
    assign accept_c   = load_valid && load_ready;

    bit_counter #(
        .Max (Width)
    ) u_bit_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (accept_c),
        .en    (tick_c),
        .count (cnt),
        .tc_c  (tc_c)
    );

    // State, shift register and registered line outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            sreg       <= {Width{IdleValue}};
            serial_out <= IdleValue;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= last_c;
            if (accept_c) begin
                state      <= SHIFT;
                sreg       <= load_data;
                serial_out <= load_data[0];
                busy       <= 1'b1;
            end else if (last_c) begin
                state      <= IDLE;
                sreg       <= {Width{IdleValue}};
                serial_out <= IdleValue;
                busy       <= 1'b0;
            end else if (tick_c) begin
                sreg       <= {IdleValue, sreg[Width-1:1]};
                serial_out <= sreg[1];
            end
        end
    end

    a_cnt_in_range: assert property (@(posedge clk) disable iff (!rst_n) cnt <= LastIdx)
        else $error("shift_out_serializer: bit counter out of range");

endmodule

// File: tb/tb_shift_out_serializer.sv
// Randomized and directed bench for shift_out_serializer with a word-level reference model
// and a shift-in scoreboard reassembling serial_out.
module tb_shift_out_serializer;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_valid = 1'b0;
    logic       load_ready;
    logic [7:0] load_data = '0;
    logic       shift_en = 1'b0;
    logic       serial_out;
    logic       busy;
    logic       done;

    logic       lv4 = 1'b0;
    logic       lr4;
    logic [3:0] ld4 = '0;
    logic       se4 = 1'b0;
    logic       so4;
    logic       busy4;
    logic       done4;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: word in flight, index of the bit on the line
    bit         m_busy = 1'b0;
    bit         m_done = 1'b0;
    logic [7:0] m_word = '0;
    int         m_idx  = 0;
    int         words_done = 0;
    int         done_seen  = 0;

    // Shift-in reference receiver
    logic [7:0] rx = '0;
    int         rx_n = 0;
    logic [7:0] exp_q[$];

    always #5 clk = ~clk;

    shift_out_serializer #(.Width(8), .IdleValue(1'b0)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_data  (load_data),
        .shift_en   (shift_en),
        .serial_out (serial_out),
        .busy       (busy),
        .done       (done)
    );

    shift_out_serializer #(.Width(4), .IdleValue(1'b1)) dut4 (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_valid (lv4),
        .load_ready (lr4),
        .load_data  (ld4),
        .shift_en   (se4),
        .serial_out (so4),
        .busy       (busy4),
        .done       (done4)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_busy = 1'b0;
        m_done = 1'b0;
        m_idx  = 0;
        rx_n   = 0;
        exp_q.delete();
    endtask

    // One clock: drive inputs, check outputs against the model, then advance the model.
    task automatic cycle(input logic v, input logic [7:0] d, input logic s, output bit accepted);
        logic exp_ready;
        logic exp_serial;
        bit   last;
        @(negedge clk);
        load_valid = v;
        load_data  = d;
        shift_en   = s;
        #1;
        last       = m_busy && s && (m_idx == 7);
        exp_ready  = !m_busy || last;
        exp_serial = m_busy ? m_word[m_idx] : 1'b0;
        check("serial_out", 32'(serial_out), 32'(exp_serial));
        check("busy", 32'(busy), 32'(m_busy));
        check("done", 32'(done), 32'(m_done));
        check("load_ready", 32'(load_ready), 32'(exp_ready));
        if (done) done_seen++;
        load_valid = !v;
        #1;
        check("ready_vs_valid", 32'(load_ready), 32'(exp_ready));
        load_valid = v;
        #1;
        if (m_busy && s) begin
            rx = {serial_out, rx[7:1]};
            rx_n++;
            if (rx_n == 8) begin
                check("rx_word", 32'(rx), (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD);
                rx_n = 0;
            end
        end
        @(posedge clk);
        accepted = v && exp_ready;
        m_done   = last;
        if (last) words_done++;
        if (accepted) begin
            m_word = d;
            m_idx  = 0;
            m_busy = 1'b1;
            exp_q.push_back(d);
        end else if (last) begin
            m_busy = 1'b0;
        end else if (m_busy && s) begin
            m_idx++;
        end
    endtask

    // Present a list of words back-to-back with load_valid held high, bounded by a cycle budget.
    task automatic send_words(input logic [7:0] w0, input logic [7:0] w1, input int n);
        logic [7:0] words[2];
        int         sent;
        bit         acc;
        words[0] = w0;
        words[1] = w1;
        sent = 0;
        for (int k = 0; k < 40 && sent < n; k++) begin
            cycle(1'b1, words[sent], 1'b1, acc);
            if (acc) sent++;
        end
        check("send_budget", 32'(sent), 32'(n));
    endtask

    initial begin
        bit         acc;
        logic [3:0] pat4;
        logic       e4_so[7];
        logic       e4_bz[7];
        logic       e4_dn[7];
        int         dn_base;
        e4_so = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        e4_bz = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        e4_dn = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

        // Reset then idle with random data and shift_en
        rst_n = 1'b0;
        #1;
        check("rst_serial", 32'(serial_out), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_ready", 32'(load_ready), 32'h1);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'($urandom), 1'($urandom), acc);

        // Single word, full rate
        cycle(1'b1, 8'hA5, 1'b1, acc);
        check("accept_a5", 32'(acc), 32'h1);
        for (int i = 0; i < 11; i++) cycle(1'b0, 8'h00, 1'b1, acc);

        // Back-to-back words with valid held high
        dn_base = done_seen;
        send_words(8'h3C, 8'hFF, 2);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, acc);
        check("b2b_done_pulses", 32'(done_seen - dn_base), 32'h2);

        // Slow bit rate: shift_en every 4th cycle
        dn_base = done_seen;
        cycle(1'b1, 8'h81, 1'b0, acc);
        for (int i = 0; i < 40; i++) cycle(1'b1, 8'h55, 1'(i % 4 == 3), acc);
        check("slow_done_pulses", 32'(done_seen - dn_base), 32'h1);
        for (int i = 0; i < 12; i++) cycle(1'b0, 8'h00, 1'b1, acc);

        // Width=4, idle-high instance
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            lv4 = (i == 0);
            pat4 = 4'b0110;
            ld4 = pat4;
            se4 = 1'b1;
            #1;
            check("w4_serial", 32'(so4), 32'(e4_so[i]));
            check("w4_busy", 32'(busy4), 32'(e4_bz[i]));
            check("w4_done", 32'(done4), 32'(e4_dn[i]));
        end
        lv4 = 1'b0;

        // Reset during the third bit of a word, then a clean word
        cycle(1'b1, 8'hF0, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b1, acc);
        cycle(1'b0, 8'h00, 1'b1, acc);
        @(negedge clk);
        load_valid = 1'b0;
        shift_en   = 1'b1;
        #1;
        check("pre_rst_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_serial", 32'(serial_out), 32'h0);
        check("mid_rst_busy", 32'(busy), 32'h0);
        check("mid_rst_ready", 32'(load_ready), 32'h1);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1'b1, 8'h0F, 1'b1, acc);
        for (int i = 0; i < 10; i++) cycle(1'b0, 8'h00, 1'b1, acc);

        // Randomized traffic
        for (int i = 0; i < 600; i++)
            cycle(1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) != 0), acc);
        for (int i = 0; i < 40; i++) cycle(1'b0, 8'h00, 1'b1, acc);
        check("tail_queue_empty", 32'(exp_q.size()), 32'h0);
        check("words_completed_min", 32'(words_done > 20), 32'h1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
